// File: rtl/arbitro_entrada_rr_pkg.sv
// Shared constants and types for the ingress round-robin arbiter.
// Class bits ride inside each word and are never decoded here.
package trans_pkg;

  localparam int NUM_PORTS          = 4;
  localparam int PORT_IDX_W         = 2;
  localparam int DEFAULT_DATA_WIDTH = 6;
  localparam int CLASS_MSB          = DEFAULT_DATA_WIDTH - 1;
  localparam int CLASS_LSB          = DEFAULT_DATA_WIDTH - 2;

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

endpackage

// File: rtl/arbitro_entrada_rr_if.sv
// Bundle of FIFO-side and observability signals around the ingress arbiter.
// The arbiter sits on the slave side; the surrounding FIFOs/bench drive the master side.
interface arbitro_entrada_rr_if
  import trans_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
);

  logic                  Enable;
  logic [NUM_PORTS-1:0]  fifo_empty;
  logic [DATA_WIDTH-1:0] data_in0;
  logic [DATA_WIDTH-1:0] data_in1;
  logic [DATA_WIDTH-1:0] data_in2;
  logic [DATA_WIDTH-1:0] data_in3;
  logic                  out_almost_full;
  logic [NUM_PORTS-1:0]  Pop;
  logic                  Push;
  logic [DATA_WIDTH-1:0] data_out;
  logic [PORT_IDX_W-1:0] grant_idx;
  logic [CNT_WIDTH-1:0]  cnt0;
  logic [CNT_WIDTH-1:0]  cnt1;
  logic [CNT_WIDTH-1:0]  cnt2;
  logic [CNT_WIDTH-1:0]  cnt3;

  modport slave (
    input  Enable, fifo_empty, data_in0, data_in1, data_in2, data_in3, out_almost_full,
    output Pop, Push, data_out, grant_idx, cnt0, cnt1, cnt2, cnt3
  );

  modport master (
    output Enable, fifo_empty, data_in0, data_in1, data_in2, data_in3, out_almost_full,
    input  Pop, Push, data_out, grant_idx, cnt0, cnt1, cnt2, cnt3
  );

endinterface

// File: rtl/arbitro_entrada_rr_rr_pick_4.sv
// Combinational round-robin picker: first eligible port after ptr, wrapping back to ptr last.
module rr_pick_4
  import trans_pkg::*;
(
  input  logic [NUM_PORTS-1:0] eligible,
  input  port_idx_t            ptr,
  output logic                 found,
  output port_idx_t            g
);

  // Search order ptr+1, ptr+2, ptr+3, ptr; the 2-bit add wraps naturally.
  always_comb begin
    found = 1'b0;
    g     = ptr;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      port_idx_t cand;
      cand = ptr + port_idx_t'(k);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        g     = cand;
      end
    end
  end

endmodule

// File: rtl/arbitro_entrada_rr.sv
// Ingress arbiter: drains four FWFT FIFOs round-robin into one shared FIFO,
// with registered pop/push and per-port transfer counters.
module arbitro_entrada_rr
  import trans_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
)(
  input logic                 clk,
  input logic                 reset,
  arbitro_entrada_rr_if.slave bus
);

  logic [DATA_WIDTH-1:0] dataIn [NUM_PORTS];
  logic [NUM_PORTS-1:0]  eligible;
  logic                  found;
  port_idx_t             pick;
  logic                  grant;

  logic [NUM_PORTS-1:0]  pop_q, pop_d;
  logic                  push_q, push_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  port_idx_t             grant_q, grant_d;
  logic [CNT_WIDTH-1:0]  cnt_q [NUM_PORTS];
  logic [CNT_WIDTH-1:0]  cnt_d [NUM_PORTS];

  assign dataIn[0] = bus.data_in0;
  assign dataIn[1] = bus.data_in1;
  assign dataIn[2] = bus.data_in2;
  assign dataIn[3] = bus.data_in3;

  // A port popped last cycle still shows its old head, so it must sit out one cycle.
  assign eligible = ~bus.fifo_empty & ~pop_q;
  assign grant    = bus.Enable && !bus.out_almost_full && found;

  rr_pick_4 u_pick (
    .eligible (eligible),
    .ptr      (grant_q),
    .found    (found),
    .g        (pick)
  );

  always_comb begin
    pop_d   = '0;
    push_d  = 1'b0;
    data_d  = data_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    if (grant) begin
      pop_d[pick] = 1'b1;
      push_d      = 1'b1;
      data_d      = dataIn[pick];
      grant_d     = pick;
      cnt_d[pick] = cnt_q[pick] + 1'b1;
    end
  end

  // grant_idx resets to 3 so that port 0 is first in line after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pop_q   <= '0;
      push_q  <= 1'b0;
      data_q  <= '0;
      grant_q <= port_idx_t'(NUM_PORTS - 1);
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
    end else begin
      pop_q   <= pop_d;
      push_q  <= push_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.Pop       = pop_q;
  assign bus.Push      = push_q;
  assign bus.data_out  = data_q;
  assign bus.grant_idx = grant_q;
  assign bus.cnt0      = cnt_q[0];
  assign bus.cnt1      = cnt_q[1];
  assign bus.cnt2      = cnt_q[2];
  assign bus.cnt3      = cnt_q[3];

endmodule

// File: tb/tb_arbitro_entrada_rr.sv
// Directed bench for the ingress arbiter: four FWFT FIFO models feed the DUT and
// every cycle's grant/data is compared against hand-derived tables.
module tb_arbitro_entrada_rr;
  import trans_pkg::*;

  typedef logic [5:0] word_t;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] popSnap;
  int nCompared   = 0;
  int nMismatched = 0;
  word_t q0[$], q1[$], q2[$], q3[$];

  always #5 clk = ~clk;

  arbitro_entrada_rr_if #(.DATA_WIDTH(6), .CNT_WIDTH(8)) ifc();

  arbitro_entrada_rr #(.DATA_WIDTH(6), .CNT_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  // Words are tagged with their port so a misrouted mux shows up as a data error.
  function automatic word_t wordOf(int p, int n);
    return word_t'(p * 8 + n);
  endfunction

  task automatic pushWord(int p, word_t w);
    case (p)
      0: q0.push_back(w);
      1: q1.push_back(w);
      2: q2.push_back(w);
      default: q3.push_back(w);
    endcase
  endtask

  task automatic popWord(int p);
    case (p)
      0: if (q0.size() > 0) void'(q0.pop_front());
      1: if (q1.size() > 0) void'(q1.pop_front());
      2: if (q2.size() > 0) void'(q2.pop_front());
      default: if (q3.size() > 0) void'(q3.pop_front());
    endcase
  endtask

  task automatic refreshFifos();
    ifc.fifo_empty = {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
    ifc.data_in0   = (q0.size() > 0) ? q0[0] : '0;
    ifc.data_in1   = (q1.size() > 0) ? q1[0] : '0;
    ifc.data_in2   = (q2.size() > 0) ? q2[0] : '0;
    ifc.data_in3   = (q3.size() > 0) ? q3[0] : '0;
  endtask

  task automatic flushFifos();
    q0.delete();
    q1.delete();
    q2.delete();
    q3.delete();
  endtask

  // FWFT FIFO behaviour: a Pop seen at a posedge retires the head just after that edge.
  always begin
    @(posedge clk);
    popSnap = ifc.Pop;
    #1;
    for (int i = 0; i < 4; i++) if (popSnap[i]) popWord(i);
    refreshFifos();
    @(negedge clk);
    #1;
    refreshFifos();
  end

  task automatic applyStimulus(int p, int nFirst, int nLast);
    for (int n = nFirst; n <= nLast; n++) pushWord(p, wordOf(p, n));
  endtask

  task automatic applyBurst(int p, int count, word_t w);
    for (int n = 0; n < count; n++) pushWord(p, w);
  endtask

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // g<0 means no grant this cycle: Pop/Push low and grant_idx holding holdG.
  task automatic checkGrant(string tag, int g, int n, int holdG);
    if (g < 0) begin
      checkOutput({tag, " push"}, 32'(ifc.Push), 32'd0);
      checkOutput({tag, " pop"}, 32'(ifc.Pop), 32'd0);
      checkOutput({tag, " gidx"}, 32'(ifc.grant_idx), 32'(holdG));
    end else begin
      checkOutput({tag, " push"}, 32'(ifc.Push), 32'd1);
      checkOutput({tag, " pop"}, 32'(ifc.Pop), 32'(1 << g));
      checkOutput({tag, " gidx"}, 32'(ifc.grant_idx), 32'(g));
      checkOutput({tag, " data"}, 32'(ifc.data_out), 32'(wordOf(g, n)));
    end
  endtask

  task automatic checkCounts(string tag, int c0, int c1, int c2, int c3);
    checkOutput({tag, " cnt0"}, 32'(ifc.cnt0), 32'(c0));
    checkOutput({tag, " cnt1"}, 32'(ifc.cnt1), 32'(c1));
    checkOutput({tag, " cnt2"}, 32'(ifc.cnt2), 32'(c2));
    checkOutput({tag, " cnt3"}, 32'(ifc.cnt3), 32'(c3));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int expG3 [6];
    int expN3 [6];
    int expG4 [16];
    int expN4 [16];
    int expG5 [13];
    int expN5 [13];
    int lastG;

    expG3 = '{2, -1, 2, -1, 2, -1};
    expN3 = '{1,  0, 2,  0, 3,  0};
    expG4 = '{3, 0, 1, -1, -1, -1, 2, 3, 0, 1, 2, 3, 0, 1, 2, -1};
    expN4 = '{1, 1, 1,  0,  0,  0, 1, 2, 2, 2, 2, 3, 3, 3, 3,  0};
    expG5 = '{3, 0, -1, -1, -1, -1, 1, 2, 3, 0, 1, 2, -1};
    expN5 = '{1, 1,  0,  0,  0,  0, 1, 1, 2, 2, 2, 2,  0};

    reset               = 1'b1;
    ifc.Enable          = 1'b1;
    ifc.out_almost_full = 1'b0;
    refreshFifos();

    for (int c = 0; c < 10; c++) begin
      tick();
      checkGrant($sformatf("rst c%0d", c), -1, 0, 3);
    end
    checkOutput("rst data", 32'(ifc.data_out), 32'd0);
    checkCounts("rst", 0, 0, 0, 0);

    // All four FIFOs hold two words: strict 0,1,2,3,0,1,2,3 with no bubbles.
    reset = 1'b0;
    for (int p = 0; p < 4; p++) applyStimulus(p, 1, 2);
    for (int k = 0; k < 8; k++) begin
      tick();
      checkGrant($sformatf("all4 c%0d", k + 1), k % 4, k / 4 + 1, 0);
    end
    tick();
    checkGrant("all4 idle", -1, 0, 3);
    checkCounts("all4", 2, 2, 2, 2);

    // Lone port 2: every other cycle because of the Pop-blocking rule.
    applyStimulus(2, 1, 3);
    for (int j = 0; j < 6; j++) begin
      tick();
      checkGrant($sformatf("lone c%0d", j + 1), expG3[j], expN3[j], 2);
    end
    checkCounts("lone", 2, 2, 5, 2);

    // Streaming with almost_full held for three edges, then resume at next port.
    for (int p = 0; p < 4; p++) applyStimulus(p, 1, 3);
    lastG = 2;
    for (int j = 0; j < 16; j++) begin
      tick();
      checkGrant($sformatf("afull c%0d", j + 1), expG4[j], expN4[j], lastG);
      if (expG4[j] >= 0) lastG = expG4[j];
      if (j == 2) ifc.out_almost_full = 1'b1;
      if (j == 5) ifc.out_almost_full = 1'b0;
    end
    checkCounts("afull", 5, 5, 8, 5);

    // Enable gap of four edges mid-stream.
    for (int p = 0; p < 4; p++) applyStimulus(p, 1, 2);
    lastG = 2;
    for (int j = 0; j < 13; j++) begin
      tick();
      checkGrant($sformatf("enable c%0d", j + 1), expG5[j], expN5[j], lastG);
      if (expG5[j] >= 0) lastG = expG5[j];
      if (j == 1) ifc.Enable = 1'b0;
      if (j == 5) ifc.Enable = 1'b1;
    end
    checkCounts("enable", 7, 7, 10, 7);

    // Bring cnt1 up to 255, then reset mid-stream.
    applyBurst(1, 248, 6'h15);
    repeat (2 * 248 + 4) tick();
    checkCounts("fill", 7, 255, 10, 7);
    checkGrant("fill idle", -1, 0, 1);
    applyStimulus(0, 1, 2);
    applyStimulus(1, 5, 5);
    tick();
    checkGrant("pre-rst", 0, 1, 1);
    checkOutput("pre-rst cnt1", 32'(ifc.cnt1), 32'd255);
    reset = 1'b1;
    tick();
    checkGrant("midrst", -1, 0, 3);
    checkOutput("midrst data", 32'(ifc.data_out), 32'd0);
    checkCounts("midrst", 0, 0, 0, 0);
    reset = 1'b0;
    flushFifos();

    // Separately: 255 transfers from port 1, then one more wraps cnt1 to zero.
    applyBurst(1, 255, 6'h15);
    repeat (2 * 255 + 4) tick();
    checkCounts("wrap pre", 0, 255, 0, 0);
    checkOutput("wrap pre data", 32'(ifc.data_out), 32'h15);
    applyBurst(1, 1, 6'h2A);
    repeat (4) tick();
    checkCounts("wrap", 0, 0, 0, 0);
    checkOutput("wrap data", 32'(ifc.data_out), 32'h2A);
    checkGrant("wrap idle", -1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
